load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 10; log2 of data-memory word count, used for range check.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline presents a load/store request.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  misaligned, illegal-funct3 or out-of-range request; valid with resp_valid.
REQ-013 SHALL have ports mem_read, mem_write (output 1), mem_addr (output 32, byte address, bits[1:0]=00), mem_wdata (output 32), mem_rdata (input 32): drive the word-wide data memory.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on a rising edge where state=IDLE and req_valid=1, registering we, funct3, addr, wdata; inputs are ignored in other states.
REQ-016 SHALL decode funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only); store 1xx and all 011/110/111 codes are illegal.
REQ-017 SHALL flag an error when: funct3 illegal; H/HU with addr[0]=1; W with addr[1:0]!=00; or addr[31:2] >= 2**DEPTH.
REQ-018 SHALL route transitions from IDLE on accept: error -> RESP; load -> RD; SW -> WR; SB/SH -> RD.
REQ-019 SHALL in RD assert mem_read=1, mem_addr={addr[31:2],2'b00}, and capture mem_rdata on the edge leaving RD.
REQ-020 SHALL route RD -> RESP for loads and RD -> WR for SB/SH.
REQ-021 SHALL in WR assert mem_write=1 for exactly one cycle with mem_addr held; SW drives mem_wdata=wdata.
REQ-022 SHALL for SB/SH in WR drive the captured word with only the addressed byte (addr[1:0]) or halfword (addr[1]) lanes replaced by wdata[7:0] or wdata[15:0], little-endian.
REQ-023 SHALL route WR -> RESP, and RESP -> IDLE unconditionally.
REQ-024 SHALL in RESP drive resp_valid=1 for exactly one cycle; no backpressure.
REQ-025 SHALL produce resp_rdata by selecting the addressed lane and extending: B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-026 SHALL latency (accept edge to resp_valid high): load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-027 SHALL never assert mem_read and mem_write together, and assert neither outside RD/WR or for erroneous requests.

Reset
REQ-028 SHALL on rst_n=0 immediately force state=IDLE and all registered fields to 0, giving req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-029 SHALL on reset asserted mid-transaction abandon it, drop mem_write combinationally without writing, and emit no response.
REQ-030 SHALL accept a new request on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL cover: word@0x10=0x8899AABB; LB addr 0x11 -> one RD cycle, resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after accept.
REQ-032 SHALL cover: same word; LHU addr 0x12 -> resp_rdata=0x00008899; LH addr 0x12 -> 0xFFFF8899.
REQ-033 SHALL cover: SB addr 0x13 wdata 0x00000055 -> RD cycle then WR cycle with mem_wdata=0x5599AABB; word becomes 0x5599AABB; resp_valid at cycle 3.
REQ-034 SHALL cover: LW addr 0x06, and SH addr 0x01 -> resp_err=1, resp_rdata=0, 1-cycle latency, no mem_read/mem_write.
REQ-035 SHALL cover: DEPTH=10, LW addr 0x00001000 -> resp_err=1, no memory access; LW addr 0x00000FFC -> normal read.
REQ-036 SHALL cover: SH addr 0x10 wdata 0x1234, rst_n pulsed low during WR -> mem_write falls immediately, word stays 0x8899AABB, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data memory.
// Sub-word stores use a read-modify-write sequence.
module load_store_unit #(
    parameter int DEPTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, next;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, word_q;
    logic        f3_ok, mis, oor, req_err;
    logic [31:0] byte_mask, half_mask, merged, lane, load_val;

    always_comb begin
        f3_ok = 1'b0;
        mis   = 1'b0;
        case (req_funct3)
            3'b000: f3_ok = 1'b1;
            3'b001: begin f3_ok = 1'b1;    mis = req_addr[0];    end
            3'b010: begin f3_ok = 1'b1;    mis = |req_addr[1:0]; end
            3'b100: f3_ok = !req_we;
            3'b101: begin f3_ok = !req_we; mis = req_addr[0];    end
            default: ;
        endcase
        // word index must fit in 2**DEPTH words
        oor     = (req_addr >> (DEPTH + 2)) != 32'd0;
        req_err = !f3_ok || mis || oor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                err_q   <= req_err;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == RD) word_q <= mem_rdata;
        end
    end

    always_comb begin
        byte_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        half_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        case (f3_q[1:0])
            2'b00:   merged = (word_q & ~byte_mask)
                            | ({4{wdata_q[7:0]}} & byte_mask);
            2'b01:   merged = (word_q & ~half_mask)
                            | ({2{wdata_q[15:0]}} & half_mask);
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        lane = word_q >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = word_q;
        endcase
    end

    always_comb begin
        next       = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                    next = RESP;
                    else if (!req_we)               next = RD;
                    else if (req_funct3 == 3'b010)  next = WR;
                    else                            next = RD;
                end
            end
            RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[31:2], 2'b00};
                next     = we_q ? WR : RESP;
            end
            WR: begin
                mem_write = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = merged;
                next      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'd0 : load_val;
                next       = IDLE;
            end
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a
// byte-level memory reference model.
module tb_load_store_unit;

    localparam int DEPTH = 10;
    localparam int WORDS = 1 << DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // environment memory seen by the DUT
    logic [31:0]      tb_mem [WORDS];
    logic             pl_en = 1'b0;
    logic [DEPTH-1:0] pl_idx = '0;
    logic [31:0]      pl_data = 32'd0;

    assign mem_rdata = tb_mem[mem_addr[DEPTH+1:2]];

    always @(posedge clk) begin
        if (mem_write)  tb_mem[mem_addr[DEPTH+1:2]] <= mem_wdata;
        else if (pl_en) tb_mem[pl_idx] <= pl_data;
    end

    // reference memory, updated only by the model
    logic [31:0] ref_mem [WORDS];

    int tests = 0;
    int fails = 0;

    logic [31:0] last_rdata, last_wdata;
    logic        last_err;
    int          last_lat;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr);
        int          size, off;
        bit          legal;
        logic [31:0] w, v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
             || (!we && (f3 == 3'd4 || f3 == 3'd5));
        off   = int'(addr % 4);
        err   = !legal || (addr % size != 0) || (addr / 4 >= WORDS);
        rdata = 32'd0;
        nrd   = 0;
        nwr   = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            nrd = 1;
            w = ref_mem[addr / 4];
            v = w >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            rdata = v;
        end else begin
            nwr = 1;
            nrd = (size < 4) ? 1 : 0;
            lat = (size < 4) ? 3 : 2;
            w = ref_mem[addr / 4];
            for (int i = 0; i < size; i++)
                w[8*(off+i) +: 8] = wdata[8*i +: 8];
            ref_mem[addr / 4] = w;
        end
    endtask

    // called right after a negedge with the DUT idle
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic        e_err;
        logic [31:0] e_rdata, e_word;
        int          e_lat, e_nrd, e_nwr;
        int          cyc, nrd, nwr, both, badaddr;
        bit          done;
        string       sfx;
        model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_nrd, e_nwr);
        e_word = e_err ? 32'd0 : ref_mem[addr / 4];
        sfx = $sformatf("%0d/%0d@%h", we, f3, addr);
        check({"ready_", sfx}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        cyc = 0; nrd = 0; nwr = 0; both = 0; badaddr = 0;
        done = 1'b0;
        last_wdata = 32'd0;
        while (!done && cyc < 8) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (mem_read)  nrd++;
            if (mem_write) begin
                nwr++;
                last_wdata = mem_wdata;
            end
            if (mem_read && mem_write) both++;
            if ((mem_read || mem_write) && mem_addr !== {addr[31:2], 2'b00})
                badaddr++;
            if (resp_valid) begin
                done       = 1'b1;
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
        end
        last_lat = cyc;
        check({"done_", sfx}, 32'(done), 32'd1);
        check({"lat_", sfx}, 32'(cyc), 32'(e_lat));
        check({"err_", sfx}, 32'(last_err), 32'(e_err));
        check({"rdata_", sfx}, last_rdata, e_rdata);
        check({"nrd_", sfx}, 32'(nrd), 32'(e_nrd));
        check({"nwr_", sfx}, 32'(nwr), 32'(e_nwr));
        check({"both_", sfx}, 32'(both), 32'd0);
        check({"maddr_", sfx}, 32'(badaddr), 32'd0);
        if (e_nwr != 0) begin
            check({"wdata_", sfx}, last_wdata, e_word);
            check({"word_", sfx}, tb_mem[addr / 4], e_word);
        end
        @(negedge clk);
        check({"rvlow_", sfx}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_addr;
        int          extra;

        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rerr", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mrd", 32'(mem_read), 32'd0);
        check("rst_mwr", 32'(mem_write), 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);

        for (int i = 0; i < WORDS; i++) begin
            @(negedge clk);
            pl_en   = 1'b1;
            pl_idx  = DEPTH'(i);
            pl_data = (i == 4) ? 32'h8899_AABB : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        rst_n = 1'b1;

        do_req(1'b0, 3'b000, 32'h11, 32'd0);
        check("lb_val", last_rdata, 32'hFFFF_FFAA);
        do_req(1'b0, 3'b101, 32'h12, 32'd0);
        check("lhu_val", last_rdata, 32'h0000_8899);
        do_req(1'b0, 3'b001, 32'h12, 32'd0);
        check("lh_val", last_rdata, 32'hFFFF_8899);
        do_req(1'b1, 3'b000, 32'h13, 32'h55);
        check("sb_wdata", last_wdata, 32'h5599_AABB);
        check("sb_lat", 32'(last_lat), 32'd3);
        do_req(1'b1, 3'b010, 32'h10, 32'h8899_AABB);
        do_req(1'b0, 3'b010, 32'h06, 32'd0);
        check("lw_mis_err", 32'(last_err), 32'd1);
        do_req(1'b1, 3'b001, 32'h01, 32'h1234);
        check("sh_mis_lat", 32'(last_lat), 32'd1);
        do_req(1'b0, 3'b010, 32'h1000, 32'd0);
        check("lw_oor_err", 32'(last_err), 32'd1);
        do_req(1'b0, 3'b010, 32'hFFC, 32'd0);
        check("lw_top_err", 32'(last_err), 32'd0);

        // reset asserted during the write cycle of a halfword store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h10;
        req_wdata  = 32'h1234;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_wr", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mwr", 32'(mem_write), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        check("rst_mid_noresp", 32'(extra), 32'd0);
        check("rst_mid_word", tb_mem[4], 32'h8899_AABB);
        rst_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h10, 32'd0);
        check("rst_after_lw", last_rdata, 32'h8899_AABB);

        for (int n = 0; n < 300; n++) begin
            r_we   = 1'($urandom % 2);
            r_f3   = 3'($urandom % 8);
            if ($urandom % 8 == 0) r_addr = $urandom;
            else r_addr = 32'($urandom_range(0, WORDS * 4 - 1));
            if ($urandom % 2 == 0) r_addr[1:0] = 2'b00;
            do_req(r_we, r_f3, r_addr, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
